// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that applies one requester's per-bit JK command per cycle to a shared bank.
// Optional owner lock is compiled in with JKARB_LOCK_EN.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*2*WIDTH-1:0]   jk_cmd,
`ifdef JKARB_LOCK_EN
    input  logic [NREQ-1:0]           lock,
`endif
    output logic [NREQ-1:0]           gnt,
    output logic [WIDTH-1:0]          q,
    output logic [WIDTH-1:0]          qb,
    output logic                      busy
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]      ptr;
    logic [NREQ-1:0]    elig;
    logic               found;
    logic [PW-1:0]      win;
    logic [PW-1:0]      win_next;
    logic [2*WIDTH-1:0] cmd;
    logic [WIDTH-1:0]   q_next;

`ifdef JKARB_LOCK_EN
    typedef enum logic [0:0] {IDLE, LOCKED} state_t;
    state_t             state;
    logic [PW-1:0]      owner;
    logic [PW-1:0]      owner_next;
`endif

    always_comb begin
        // Last cycle's grantee is masked so a held req is never applied twice in a row.
        elig = req & ~gnt;
`ifdef JKARB_LOCK_EN
        if (state == LOCKED)
            elig = elig & (NREQ'(1) << owner);
`endif
        found = 1'b0;
        win   = '0;
        // Descending scan: the last hit is the closest index at or after ptr.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + k) % NREQ);
            end
        end
        win_next = PW'((int'(win) + 1) % NREQ);
        cmd      = jk_cmd[int'(win)*2*WIDTH +: 2*WIDTH];
        for (int b = 0; b < WIDTH; b++) begin
            case (cmd[2*b +: 2])
                2'b00:   q_next[b] = q[b];
                2'b01:   q_next[b] = 1'b0;
                2'b10:   q_next[b] = 1'b1;
                default: q_next[b] = ~q[b];
            endcase
        end
    end

`ifdef JKARB_LOCK_EN
    assign owner_next = PW'((int'(owner) + 1) % NREQ);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            gnt <= '0;
            ptr <= '0;
`ifdef JKARB_LOCK_EN
            state <= IDLE;
            owner <= '0;
            busy  <= 1'b0;
`endif
        end else begin
            gnt <= '0;
            if (found) begin
                q   <= q_next;
                gnt <= NREQ'(1) << win;
                ptr <= win_next;
            end
`ifdef JKARB_LOCK_EN
            case (state)
                IDLE: begin
                    if (found && lock[win]) begin
                        state <= LOCKED;
                        owner <= win;
                        busy  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!lock[owner]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= owner_next;
                    end
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

`ifndef JKARB_LOCK_EN
    assign busy = 1'b0;
`endif

    assign qb = ~q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter (NREQ=4, WIDTH=4).
// Lock steps run only when JKARB_LOCK_EN is defined.
module tb_jk_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] jk_cmd;
`ifdef JKARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic [3:0]  qb;
    logic        busy;

    int npass = 0;
    int ntotal = 0;

    jk_bank_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .jk_cmd (jk_cmd),
`ifdef JKARB_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .q      (q),
        .qb     (qb),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // JK pair per bit: 10 where p is 1, 01 where p is 0, so the bank lands on p.
    function automatic logic [7:0] setpat(input logic [3:0] p);
        logic [7:0] c;
        for (int b = 0; b < 4; b++)
            c[2*b +: 2] = p[b] ? 2'b10 : 2'b01;
        return c;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fair_cmds;
        jk_cmd = {setpat(4'b1001), setpat(4'b1100), setpat(4'b0110), setpat(4'b0011)};
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        fair_cmds();
`ifdef JKARB_LOCK_EN
        lock = 4'b0000;
`endif
        step();
        check("rst_q",    8'(q),    8'h0);
        check("rst_qb",   8'(qb),   8'hF);
        check("rst_gnt",  8'(gnt),  8'h0);
        check("rst_busy", 8'(busy), 8'h0);
        #4 rst = 1'b0;

        step(); check("fair0_q", 8'(q), 8'h3); check("fair0_gnt", 8'(gnt), 8'h1);
        step(); check("fair1_q", 8'(q), 8'h6); check("fair1_gnt", 8'(gnt), 8'h2);
        step(); check("fair2_q", 8'(q), 8'hC); check("fair2_gnt", 8'(gnt), 8'h4);
        step(); check("fair3_q", 8'(q), 8'h9); check("fair3_gnt", 8'(gnt), 8'h8);
        step(); check("fair4_q", 8'(q), 8'h3); check("fair4_gnt", 8'(gnt), 8'h1);

        #2 rst = 1'b1;
        #1;
        check("arst_q",   8'(q),   8'h0);
        check("arst_qb",  8'(qb),  8'hF);
        check("arst_gnt", 8'(gnt), 8'h0);
        #3 rst = 1'b0;
        step(); check("restart_q", 8'(q), 8'h3); check("restart_gnt", 8'(gnt), 8'h1);

        req = 4'b0000;
        step(); check("idle_q", 8'(q), 8'h3); check("idle_gnt", 8'(gnt), 8'h0);

        req = 4'b0001;
        jk_cmd[7:0] = 8'hAA;
        step(); check("set_q", 8'(q), 8'hF); check("set_gnt", 8'(gnt), 8'h1);
        jk_cmd[7:0] = 8'h55;
        step(); check("mask_q", 8'(q), 8'hF); check("mask_gnt", 8'(gnt), 8'h0);
        step(); check("clr_q", 8'(q), 8'h0); check("clr_gnt", 8'(gnt), 8'h1);

        req = 4'b0010;
        jk_cmd[15:8] = setpat(4'b0101);
        step(); check("pre_q", 8'(q), 8'h5); check("pre_gnt", 8'(gnt), 8'h2);
        req = 4'b0100;
        jk_cmd[23:16] = 8'hCC;
        step(); check("tog_q", 8'(q), 8'hF); check("tog_gnt", 8'(gnt), 8'h4);
        req = 4'b1000;
        jk_cmd[31:24] = 8'hC3;
        step(); check("tog2_q", 8'(q), 8'h6); check("tog2_gnt", 8'(gnt), 8'h8);
        req = 4'b0001;
        jk_cmd[7:0] = 8'h00;
        step(); check("nop_q", 8'(q), 8'h6); check("nop_gnt", 8'(gnt), 8'h1);
        check("nop_busy", 8'(busy), 8'h0);

`ifdef JKARB_LOCK_EN
        req = 4'b1111;
        lock = 4'b0010;
        fair_cmds();
        step(); check("lk0_gnt", 8'(gnt), 8'h2); check("lk0_busy", 8'(busy), 8'h1);
        check("lk0_q", 8'(q), 8'h6);
        step(); check("lk1_gnt", 8'(gnt), 8'h0); check("lk1_busy", 8'(busy), 8'h1);
        step(); check("lk2_gnt", 8'(gnt), 8'h2); check("lk2_busy", 8'(busy), 8'h1);
        lock = 4'b0000;
        step(); check("ul_gnt", 8'(gnt), 8'h0); check("ul_busy", 8'(busy), 8'h0);
        step(); check("ul_next_gnt", 8'(gnt), 8'h4); check("ul_next_q", 8'(q), 8'hC);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
